// File: rtl/primitive_sequencer.sv
// Frame sequencer: fetches each primitive from vertex memory, then runs shader, projection and rasterizer via start/done handshakes.
// Starts are registered one-cycle pulses; a done is honoured from the cycle after its start, and watchdogs bound every wait.
module primitive_sequencer #(
    parameter int VERTS     = 3,
    parameter int COORD_W   = 32,
    parameter int ADDR_W    = 12,
    parameter int MEM_LAT   = 1,
    parameter int MAX_PRIMS = 1024,
    parameter int TIMEOUT   = 65535
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           frame_start_i,
    input  logic                           continuous_i,
    input  logic                           vsync_i,
    output logic [ADDR_W-1:0]              mem_addr_o,
    input  logic [3*COORD_W-1:0]           mem_q_i,
    output logic                           clr_start_o,
    input  logic                           clr_done_i,
    output logic                           sh_start_o,
    input  logic                           sh_done_i,
    output logic                           xf_start_o,
    input  logic                           xf_done_i,
    output logic [3*COORD_W-1:0]           xf_in_o,
    input  logic [3*COORD_W-1:0]           xf_out_i,
    output logic                           rs_start_o,
    input  logic                           rs_done_i,
    output logic [VERTS*3*COORD_W-1:0]     verts_o,
    output logic                           busy_o,
    output logic                           frame_done_o,
    output logic [ADDR_W-1:0]              prim_count_o,
    output logic                           timeout_err_o
);
    localparam int W3  = 3 * COORD_W;
    localparam int VW  = VERTS * W3;
    localparam int FCW = $clog2(VERTS + MEM_LAT);
    localparam int KW  = $clog2(VERTS);
    localparam int PW  = $clog2(MAX_PRIMS + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_SHADE   = 3'd3;
    localparam logic [2:0] S_XFORM   = 3'd4;
    localparam logic [2:0] S_RASTER  = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_WAIT_VS = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [PW-1:0]     pidx_q, pidx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              inc_q, inc_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [KW-1:0]     xk_q, xk_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [VW-1:0]     verts_q, verts_d;
    logic [ADDR_W-1:0] prim_count_q, prim_count_d;
    logic              terr_q, terr_d;
    logic              clr_start_q, clr_start_d;
    logic              sh_start_q, sh_start_d;
    logic              xf_start_q, xf_start_d;
    logic              rs_start_q, rs_start_d;
    logic              fdone_q, fdone_d;
    logic              vs_q;
    logic              wd_hit, new_frame, eof, to_fetch;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        pidx_d       = pidx_q;
        cnt_d        = cnt_q;
        inc_d        = inc_q;
        fcnt_d       = fcnt_q;
        xk_d         = xk_q;
        wd_d         = wd_q + WDW'(1);
        mem_addr_d   = mem_addr_q;
        verts_d      = verts_q;
        prim_count_d = prim_count_q;
        terr_d       = terr_q;
        clr_start_d  = 1'b0;
        sh_start_d   = 1'b0;
        xf_start_d   = 1'b0;
        rs_start_d   = 1'b0;
        fdone_d      = 1'b0;
        new_frame    = 1'b0;
        eof          = 1'b0;
        to_fetch     = 1'b0;
        wd_hit       = (wd_q == WDW'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    new_frame = 1'b1;
                    terr_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_done_i && !clr_start_q) begin
                    to_fetch = 1'b1;
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    inc_d   = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_FETCH: begin
                fcnt_d = fcnt_q + FCW'(1);
                if (fcnt_q < FCW'(VERTS - 1)) mem_addr_d = mem_addr_q + ADDR_W'(1);
                for (int v = 0; v < VERTS; v++) begin
                    if (fcnt_q == FCW'(v + MEM_LAT)) verts_d[v*W3 +: W3] = mem_q_i;
                end
                // Sentinel is judged on vertex 0 only; later addresses already issued are harmless.
                if (fcnt_q == FCW'(MEM_LAT) && (&mem_q_i[W3-1 -: COORD_W])) begin
                    eof        = 1'b1;
                    mem_addr_d = mem_addr_q;
                end else if (fcnt_q == FCW'(VERTS + MEM_LAT - 1)) begin
                    state_d    = S_SHADE;
                    sh_start_d = 1'b1;
                    wd_d       = '0;
                end
            end
            S_SHADE: begin
                if (sh_done_i && !sh_start_q) begin
                    state_d    = S_XFORM;
                    xk_d       = '0;
                    xf_start_d = 1'b1;
                    wd_d       = '0;
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    inc_d   = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_XFORM: begin
                if (xf_done_i && !xf_start_q) begin
                    for (int v = 0; v < VERTS; v++) begin
                        if (xk_q == KW'(v)) verts_d[v*W3 +: W3] = xf_out_i;
                    end
                    wd_d = '0;
                    if (xk_q == KW'(VERTS - 1)) begin
                        state_d    = S_RASTER;
                        rs_start_d = 1'b1;
                    end else begin
                        xk_d       = xk_q + KW'(1);
                        xf_start_d = 1'b1;
                    end
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    inc_d   = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_RASTER: begin
                // A stalled rasterizer still counts: the primitive was handed over.
                if (rs_done_i && !rs_start_q) begin
                    inc_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    inc_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                base_d = base_q + ADDR_W'(VERTS);
                pidx_d = pidx_q + PW'(1);
                cnt_d  = cnt_q + ADDR_W'(inc_q);
                if (pidx_d == PW'(MAX_PRIMS)) eof = 1'b1;
                else                          to_fetch = 1'b1;
            end
            S_WAIT_VS: begin
                if (!continuous_i)            state_d = S_IDLE;
                else if (vs_q && !vsync_i)    new_frame = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_fetch) begin
            state_d    = S_FETCH;
            fcnt_d     = '0;
            mem_addr_d = base_d;
        end
        if (new_frame) begin
            state_d     = S_CLEAR;
            base_d      = '0;
            pidx_d      = '0;
            cnt_d       = '0;
            clr_start_d = 1'b1;
            wd_d        = '0;
        end
        if (eof) begin
            prim_count_d = cnt_d;
            fdone_d      = 1'b1;
            state_d      = continuous_i ? S_WAIT_VS : S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            pidx_q       <= '0;
            cnt_q        <= '0;
            inc_q        <= 1'b0;
            fcnt_q       <= '0;
            xk_q         <= '0;
            wd_q         <= '0;
            mem_addr_q   <= '0;
            verts_q      <= '0;
            prim_count_q <= '0;
            terr_q       <= 1'b0;
            clr_start_q  <= 1'b0;
            sh_start_q   <= 1'b0;
            xf_start_q   <= 1'b0;
            rs_start_q   <= 1'b0;
            fdone_q      <= 1'b0;
            vs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            pidx_q       <= pidx_d;
            cnt_q        <= cnt_d;
            inc_q        <= inc_d;
            fcnt_q       <= fcnt_d;
            xk_q         <= xk_d;
            wd_q         <= wd_d;
            mem_addr_q   <= mem_addr_d;
            verts_q      <= verts_d;
            prim_count_q <= prim_count_d;
            terr_q       <= terr_d;
            clr_start_q  <= clr_start_d;
            sh_start_q   <= sh_start_d;
            xf_start_q   <= xf_start_d;
            rs_start_q   <= rs_start_d;
            fdone_q      <= fdone_d;
            vs_q         <= vsync_i;
        end
    end

    always_comb begin
        xf_in_o = '0;
        for (int v = 0; v < VERTS; v++) begin
            if (xk_q == KW'(v)) xf_in_o = verts_q[v*W3 +: W3];
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign clr_start_o   = clr_start_q;
    assign sh_start_o    = sh_start_q;
    assign xf_start_o    = xf_start_q;
    assign rs_start_o    = rs_start_q;
    assign verts_o       = verts_q;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = fdone_q;
    assign prim_count_o  = prim_count_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_primitive_sequencer.sv
// Directed bench: instance A (MEM_LAT=1, MAX_PRIMS=3, TIMEOUT=16) with memory and done responders,
// instance B (MEM_LAT=3) whose memory always returns the sentinel.
`timescale 1ns/1ps
module tb_primitive_sequencer;
    localparam logic [95:0] SENT = {32'hFFFF_FFFF, 64'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         fs = 1'b0, cont = 1'b0, vsync = 1'b1, sh_en = 1'b1;
    logic [11:0]  mem_addr, prim_count;
    logic [95:0]  mem_q = '0, xf_in, xf_out;
    logic [287:0] verts;
    logic         clr_start, clr_done, sh_start, sh_done, xf_start, xf_done, rs_start, rs_done;
    logic         busy, fdone, terr;
    logic [95:0]  mem [0:15];

    logic         fs_b = 1'b0;
    logic [95:0]  b_mem_q = SENT;
    logic [11:0]  b_mem_addr, b_pc;
    logic [95:0]  b_xf_in;
    logic [287:0] b_verts;
    logic         b_clr, b_sh, b_xf, b_rs, b_busy, b_fd, b_terr;

    primitive_sequencer #(.VERTS(3), .COORD_W(32), .ADDR_W(12), .MEM_LAT(1), .MAX_PRIMS(3), .TIMEOUT(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .continuous_i(cont), .vsync_i(vsync),
        .mem_addr_o(mem_addr), .mem_q_i(mem_q),
        .clr_start_o(clr_start), .clr_done_i(clr_done), .sh_start_o(sh_start), .sh_done_i(sh_done),
        .xf_start_o(xf_start), .xf_done_i(xf_done), .xf_in_o(xf_in), .xf_out_i(xf_out),
        .rs_start_o(rs_start), .rs_done_i(rs_done), .verts_o(verts), .busy_o(busy),
        .frame_done_o(fdone), .prim_count_o(prim_count), .timeout_err_o(terr));

    primitive_sequencer #(.VERTS(3), .COORD_W(32), .ADDR_W(12), .MEM_LAT(3), .MAX_PRIMS(1024), .TIMEOUT(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs_b), .continuous_i(1'b0), .vsync_i(1'b1),
        .mem_addr_o(b_mem_addr), .mem_q_i(b_mem_q),
        .clr_start_o(b_clr), .clr_done_i(1'b1), .sh_start_o(b_sh), .sh_done_i(1'b0),
        .xf_start_o(b_xf), .xf_done_i(1'b0), .xf_in_o(b_xf_in), .xf_out_i(96'h0),
        .rs_start_o(b_rs), .rs_done_i(1'b0), .verts_o(b_verts), .busy_o(b_busy),
        .frame_done_o(b_fd), .prim_count_o(b_pc), .timeout_err_o(b_terr));

    // Memory with one cycle of read latency; each unit answers 4 cycles after its start.
    logic [3:0] clr_p = '0, sh_p = '0, xf_p = '0, rs_p = '0;
    always @(posedge clk) begin
        mem_q <= mem[mem_addr[3:0]];
        clr_p <= {clr_p[2:0], clr_start};
        sh_p  <= {sh_p[2:0], sh_start};
        xf_p  <= {xf_p[2:0], xf_start};
        rs_p  <= {rs_p[2:0], rs_start};
    end
    assign clr_done = clr_p[3];
    assign sh_done  = sh_p[3] & sh_en;
    assign xf_done  = xf_p[3];
    assign rs_done  = rs_p[3];
    assign xf_out   = {xf_in[95:64] + 32'd1, xf_in[63:32] + 32'd1, xf_in[31:0] + 32'd1};

    logic [63:0]  seq = '0, addr_seq = '0;
    logic [11:0]  last_addr = '0;
    logic [287:0] rv0 = '0, rv1 = '0;
    int clr_cnt = 0, xf_cnt = 0, rs_cnt = 0, fd_cnt = 0, clr_cyc = 0, sh_cyc = 0, terr_cyc = 0;
    int b_clr_cyc = 0, b_fd_cyc = 0, b_fd_cnt = 0, b_sh_cnt = 0;
    logic terr_prev = 1'b0;

    always @(negedge clk) begin
        if (clr_start) begin seq = {seq[59:0], 4'h1}; clr_cnt++; clr_cyc = cyc; end
        if (sh_start)  begin seq = {seq[59:0], 4'h2}; sh_cyc = cyc; end
        if (xf_start)  begin seq = {seq[59:0], 4'h3}; xf_cnt++; end
        if (rs_start) begin
            seq = {seq[59:0], 4'h4};
            if (rs_cnt == 0) rv0 = verts;
            if (rs_cnt == 1) rv1 = verts;
            rs_cnt++;
        end
        if (fdone) fd_cnt++;
        if (terr && !terr_prev) terr_cyc = cyc;
        terr_prev = terr;
        if (mem_addr != last_addr) begin addr_seq = {addr_seq[59:0], mem_addr[3:0]}; last_addr = mem_addr; end
        if (b_clr) b_clr_cyc = cyc;
        if (b_sh) b_sh_cnt++;
        if (b_fd) begin b_fd_cnt++; b_fd_cyc = cyc; end
    end

    int n_pass = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        tick(); fs = 1'b1;
        tick(); fs = 1'b0;
    endtask

    task automatic wait_fd(input int n, input string tag);
        int c = 0;
        while (fd_cnt < n && c < 400) begin tick(); c++; end
        chk(tag, fd_cnt >= n, 1);
    endtask

    function automatic logic [95:0] vtx(input int a, input int d);
        return {32'(3*a + 1 + d), 32'(3*a + 2 + d), 32'(3*a + 3 + d)};
    endfunction

    task automatic clear_logs();
        seq = '0; clr_cnt = 0; xf_cnt = 0; rs_cnt = 0; fd_cnt = 0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 16; i++) mem[i] = vtx(i, 0);

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", fdone, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_verts", verts, 0);
        chk("rst_xf_in", xf_in, 0);
        chk("rst_prim_count", prim_count, 0);
        chk("rst_timeout_err", terr, 0);
        chk("rst_starts", {clr_start, sh_start, xf_start, rs_start}, 0);
        rst_n = 1'b1;
        tick();

        // Two triangles then the sentinel
        mem[6] = SENT;
        clear_logs(); addr_seq = '0; last_addr = mem_addr;
        pulse_fs();
        wait_fd(1, "t1_frame_done_seen");
        repeat (5) tick();
        chk("t1_start_seq", seq, 64'h1233342333_4);
        chk("t1_frame_done_once", fd_cnt, 1);
        chk("t1_prim_count", prim_count, 2);
        chk("t1_addr_seq", addr_seq, 64'h1234567);
        chk("t1_verts_prim0", rv0, {vtx(2, 1), vtx(1, 1), vtx(0, 1)});
        chk("t1_verts_prim1", rv1, {vtx(5, 1), vtx(4, 1), vtx(3, 1)});
        chk("t1_idle", busy, 0);
        chk("t1_no_timeout", terr, 0);

        // Sentinel at address 0 with MEM_LAT=3
        tick(); fs_b = 1'b1; tick(); fs_b = 1'b0;
        c = 0;
        while (b_fd_cnt < 1 && c < 100) begin tick(); c++; end
        chk("b_frame_done_seen", b_fd_cnt >= 1, 1);
        repeat (3) tick();
        chk("b_fetch_exit_timing", b_fd_cyc - b_clr_cyc, 6);
        chk("b_prim_count", b_pc, 0);
        chk("b_no_shade", b_sh_cnt, 0);
        chk("b_idle", b_busy, 0);
        chk("b_verts_only_v0", b_verts, {192'h0, SENT});
        chk("b_mem_addr", b_mem_addr, 2);

        // MAX_PRIMS limit ends the frame with no sentinel
        mem[6] = vtx(6, 0);
        clear_logs();
        pulse_fs();
        wait_fd(1, "t2_frame_done_seen");
        repeat (3) tick();
        chk("t2_start_seq", seq, 64'h1233342333423334);
        chk("t2_prim_count", prim_count, 3);
        chk("t2_mem_addr", mem_addr, 8);
        chk("t2_frame_done_once", fd_cnt, 1);

        // Shader stalls on the first primitive
        mem[6] = SENT;
        clear_logs(); sh_en = 1'b0;
        pulse_fs();
        c = 0;
        while (!terr && c < 200) begin tick(); c++; end
        chk("t3_timeout_seen", terr, 1);
        chk("t3_timeout_delay", terr_cyc - sh_cyc, 16);
        sh_en = 1'b1;
        wait_fd(1, "t3_frame_done_seen");
        repeat (3) tick();
        chk("t3_start_seq", seq, 64'h1223334);
        chk("t3_prim_count", prim_count, 1);
        chk("t3_timeout_sticky", terr, 1);

        // Continuous mode gated by vsync
        mem[3] = SENT;
        clear_logs(); cont = 1'b1;
        pulse_fs();
        tick();
        chk("t4_timeout_cleared", terr, 0);
        wait_fd(1, "t4_frame1_done");
        repeat (20) tick();
        chk("t4_waiting_no_restart", clr_cnt, 1);
        chk("t4_waiting_busy", busy, 1);
        chk("t4_prim_count", prim_count, 1);
        vsync = 1'b0;
        c = cyc;
        tick();
        chk("t4_restart_after_vsync", clr_cyc - c, 1);
        chk("t4_second_clear", clr_cnt, 2);
        repeat (2) tick();
        vsync = 1'b1;
        wait_fd(2, "t4_frame2_done");
        repeat (3) tick();
        chk("t4_still_waiting", busy, 1);
        cont = 1'b0;
        repeat (2) tick();
        chk("t4_drop_to_idle", busy, 0);
        chk("t4_clear_count", clr_cnt, 2);

        // Reset in the middle of XFORM
        clear_logs();
        pulse_fs();
        c = 0;
        while (xf_cnt < 2 && c < 200) begin tick(); c++; end
        chk("t5_in_xform", xf_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_verts", verts, 0);
        chk("t5_async_xf_in", xf_in, 0);
        chk("t5_async_mem_addr", mem_addr, 0);
        chk("t5_async_prim_count", prim_count, 0);
        chk("t5_async_starts", {clr_start, sh_start, xf_start, rs_start, fdone}, 0);
        repeat (3) tick();
        chk("t5_no_frame_done", fd_cnt, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        clear_logs();
        pulse_fs();
        wait_fd(1, "t5_clean_frame_done");
        repeat (3) tick();
        chk("t5_clean_seq", seq, 64'h123334);
        chk("t5_clean_prim_count", prim_count, 1);
        chk("t5_clean_frame_done_once", fd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/primitive_sequencer.md
# primitive_sequencer

Parametrised frame-level control FSM for the graphics pipeline. It walks a packed vertex memory one primitive at a time and latches each primitive's vertices. It then drives the shader, projection and rasterizer units in turn through start/done handshakes, ending each frame on a sentinel word or a primitive-count limit. It replaces the hard-wired three-vertex sequencing in the top level and adds a clear pass, vsync-gated continuous mode, per-unit watchdogs and status counters.

## Interface
- VERTS, 3: vertices per primitive (2..4).
- COORD_W, 32: width of one coordinate word (IEEE-754 single at 32).
- ADDR_W, 12: vertex memory address width.
- MEM_LAT, 1: vertex memory read latency in cycles (1..3).
- MAX_PRIMS, 1024: primitives per frame before forced end of frame.
- TIMEOUT, 65535: cycles to wait for any unit's done before abandoning it.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse: begin one frame (ignored unless IDLE).
- continuous  in  1  level: after frame end, wait vsync and re-run.
- vsync  in  1  VGA vertical sync (active-low, already in clk domain).
- mem_addr  out  ADDR_W  vertex memory read address.
- mem_q  in  3*COORD_W  vertex word {x,y,z}, x in MSBs.
- clr_start / clr_done  out / in  1  frame/z-buffer clear handshake.
- sh_start / sh_done  out / in  1  shader handshake.
- xf_start / xf_done  out / in  1  projection handshake.
- xf_in  out  3*COORD_W  vertex to project.
- xf_out  in  3*COORD_W  projected vertex.
- rs_start / rs_done  out / in  1  rasterizer handshake.
- verts  out  VERTS*3*COORD_W  latched primitive, vertex 0 in LSBs.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- prim_count  out  ADDR_W  primitives rasterized in the last completed frame.
- timeout_err  out  1  sticky; set on any watchdog expiry; cleared by frame_start.

## Operation
- States: IDLE, CLEAR, FETCH, SHADE, XFORM, RASTER, NEXT, WAIT_VS.
- IDLE: on frame_start, go to CLEAR. base<=0, prim_idx<=0, running count<=0, timeout_err<=0.
- CLEAR: pulse clr_start, wait clr_done, go to FETCH.
- FETCH: issue addresses base+k for k=0..VERTS-1 on consecutive cycles. Capture mem_q into vertex k exactly MEM_LAT cycles after address k.
  - When vertex 0 is captured with x==all-ones, abandon the fetch and go to end of frame. Vertices 1..VERTS-1 are not written.
  - After all vertices are captured, go to SHADE.
- SHADE: pulse sh_start, wait sh_done, go to XFORM.
- XFORM: for k=0..VERTS-1, present vertex k on xf_in and pulse xf_start. On xf_done, write xf_out into vertex k. Go to RASTER after the last vertex.
- RASTER: pulse rs_start, wait rs_done, go to NEXT.
- NEXT: base<=base+VERTS (wraps mod 2^ADDR_W), prim_idx+1, count+1.
  - prim_idx+1==MAX_PRIMS: go to end of frame.
  - Otherwise go to FETCH.
- End of frame: prim_count<=count, pulse frame_done.
  - continuous=1: go to WAIT_VS.
  - continuous=0: go to IDLE.
- WAIT_VS: wait for a falling edge of vsync (registered previous value 1, current 0), then restart as from frame_start.
  - timeout_err is not cleared on this restart.
  - If continuous drops while waiting, go to IDLE.
- Watchdog: a counter runs in every wait-for-done state and is cleared on each start pulse.
  - On reaching TIMEOUT, set timeout_err. CLEAR, SHADE and XFORM skip the primitive and go to NEXT without counting it. RASTER goes to NEXT and does count the primitive.
- A done asserted in the same cycle as its start pulse is ignored. Done is honoured from the cycle after the start pulse onward.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE. All starts=0, busy=0, frame_done=0, mem_addr=0, verts=0, xf_in=0, prim_count=0, timeout_err=0.
- All start outputs are registered, exactly one cycle wide.
- FETCH lasts VERTS+MEM_LAT cycles (FETCH entry to SHADE entry). mem_addr holds for one cycle per vertex.
- A done arriving N cycles after its start advances the state on the next edge.
- Overhead: one FETCH-to-SHADE cycle plus one NEXT cycle per primitive.
- frame_start while busy is ignored. Reset mid-frame aborts immediately with no frame_done.

## Test plan
- VERTS=3, MEM_LAT=1, memory holds 2 triangles then the sentinel, all units with done 4 cycles after start:
  - Sequence is clr, then (sh, 3×xf, rs)×2.
  - frame_done fires once; prim_count=2.
  - mem_addr reads 0..5, then 6.
- xf_out = xf_in + 1 per coordinate: verts at rs_start shows every coordinate incremented exactly once.
- MEM_LAT=3, sentinel at address 0: FETCH exits 4 cycles after entry; frame_done fires; prim_count=0; sh_start is never asserted.
- Shader never asserts done, TIMEOUT=16, 2 primitives:
  - timeout_err set 16 cycles after sh_start.
  - Primitive skipped; second primitive rasterized; prim_count=1.
- continuous=1, one primitive: second clr_start occurs only after a vsync falling edge. Drop continuous during WAIT_VS: state returns to IDLE, busy=0.
- Assert reset_n low mid-XFORM: outputs go to reset values asynchronously with no frame_done. frame_start after release runs a clean frame.
